// File: rtl/conv_seq_pkg.sv
// Shared types and layer-size helpers for the conv layer sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_B,
        S_LOAD_I,
        S_START,
        S_RUN,
        S_FINISH
    } seq_state_e;

    function automatic int n_w(input int ic, input int oc, input int k);
        return oc * ic * k * k;
    endfunction

    function automatic int n_i(input int ic, input int h, input int w);
        return ic * h * w;
    endfunction

    function automatic int n_o(input int oc, input int h, input int w, input int k);
        return oc * (h - k + 1) * (w - k + 1);
    endfunction

    // Keeps a one-entry memory at a usable 1-bit address.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/conv_seq_load_ctr.sv
// Beat counter shared by all load phases: reloadable terminal count,
// increments on each accepted beat, flags the final beat of the phase.
module conv_seq_load_ctr #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          load_i,
    input  logic [CW-1:0] tc_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tc_q,  tc_d;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = tc_q;
        if (load_i) begin
            cnt_d = '0;
            tc_d  = tc_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            tc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == tc_q);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs one conv layer per command: loads weights/bias/input into the core, starts it,
// forwards and counts results. Optional RUN watchdog enabled by CONV_SEQ_WATCHDOG_EN.
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int INPUT_CHANNELS  = 64,
    parameter int OUTPUT_CHANNELS = 128,
    parameter int KERNEL_SIZE     = 3,
    parameter int INPUT_WIDTH     = 30,
    parameter int INPUT_HEIGHT    = 30
`ifdef CONV_SEQ_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES  = 2**24
`endif
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_reload_i,
    input  logic [31:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [7:0]  weight_data_in_o,
    output logic        weight_we_o,
    output logic [addr_w(n_w(INPUT_CHANNELS, OUTPUT_CHANNELS, KERNEL_SIZE))-1:0] weight_addr_o,
    output logic [31:0] bias_data_in_o,
    output logic        bias_we_o,
    output logic [addr_w(OUTPUT_CHANNELS)-1:0] bias_addr_o,
    output logic [7:0]  input_data_in_o,
    output logic        input_we_o,
    output logic [addr_w(n_i(INPUT_CHANNELS, INPUT_HEIGHT, INPUT_WIDTH))-1:0] input_addr_o,
    output logic        start_o,
    input  logic        done_i,
    input  logic [7:0]  conv_result_i,
    input  logic        conv_valid_i,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    output logic        busy_o,
    output logic        layer_done_o,
    output logic        count_err_o,
    output logic        timeout_err_o
);

    localparam int N_W  = n_w(INPUT_CHANNELS, OUTPUT_CHANNELS, KERNEL_SIZE);
    localparam int N_B  = OUTPUT_CHANNELS;
    localparam int N_I  = n_i(INPUT_CHANNELS, INPUT_HEIGHT, INPUT_WIDTH);
    localparam int N_O  = n_o(OUTPUT_CHANNELS, INPUT_HEIGHT, INPUT_WIDTH, KERNEL_SIZE);
    localparam int AW_W = addr_w(N_W);
    localparam int AW_B = addr_w(N_B);
    localparam int AW_I = addr_w(N_I);
    localparam int CW   = addr_w(max3(N_W, N_B, N_I));
    localparam int OW   = $clog2(N_O + 1);

    localparam logic [CW-1:0] TC_W     = CW'(N_W - 1);
    localparam logic [CW-1:0] TC_B     = CW'(N_B - 1);
    localparam logic [CW-1:0] TC_I     = CW'(N_I - 1);
    localparam logic [OW-1:0] OUT_FULL = OW'(N_O);
    localparam logic [OW-1:0] OUT_LAST = OW'(N_O - 1);

    seq_state_e      state_q;
    logic            params_valid_q;
    logic [OW-1:0]   out_cnt_q, out_cnt_d;
    logic            count_err_q;
    logic            w_we_q, b_we_q, i_we_q;
    logic [AW_W-1:0] w_addr_q;
    logic [AW_B-1:0] b_addr_q;
    logic [AW_I-1:0] i_addr_q;
    logic [7:0]      w_data_q, i_data_q;
    logic [31:0]     b_data_q;
    logic            start_q, m_valid_q, m_last_q, layer_done_q;
    logic [7:0]      m_data_q;

    logic            ld_load, ld_inc, ld_last;
    logic [CW-1:0]   ld_tc, ld_cnt;
    logic            go_w;

    assign go_w = cmd_reload_i || !params_valid_q;

    always_comb begin
        ld_load = 1'b0;
        ld_inc  = 1'b0;
        ld_tc   = TC_I;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    ld_load = 1'b1;
                    ld_tc   = go_w ? TC_W : TC_I;
                end
            end
            S_LOAD_W: begin
                if (s_valid_i) begin
                    ld_load = ld_last;
                    ld_inc  = !ld_last;
                    ld_tc   = TC_B;
                end
            end
            S_LOAD_B: begin
                if (s_valid_i) begin
                    ld_load = ld_last;
                    ld_inc  = !ld_last;
                end
            end
            S_LOAD_I: ld_inc = s_valid_i && !ld_last;
            default: ;
        endcase
    end

    conv_seq_load_ctr #(.CW(CW)) u_load_ctr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (ld_load),
        .tc_i   (ld_tc),
        .inc_i  (ld_inc),
        .cnt_o  (ld_cnt),
        .last_o (ld_last)
    );

    // Saturates so results beyond the expected count cannot wrap back to a match.
    assign out_cnt_d = (conv_valid_i && out_cnt_q != OUT_FULL) ? out_cnt_q + 1'b1 : out_cnt_q;

`ifdef CONV_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    // Trip value puts layer_done exactly TIMEOUT_CYCLES after the last result.
    localparam logic [WDW-1:0] WD_LIMIT = WDW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);
    logic [WDW-1:0] wd_q;
    logic           timeout_err_q;
    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= S_IDLE;
            params_valid_q <= 1'b0;
            out_cnt_q      <= '0;
            count_err_q    <= 1'b0;
            w_we_q         <= 1'b0;
            b_we_q         <= 1'b0;
            i_we_q         <= 1'b0;
            w_addr_q       <= '0;
            b_addr_q       <= '0;
            i_addr_q       <= '0;
            w_data_q       <= '0;
            b_data_q       <= '0;
            i_data_q       <= '0;
            start_q        <= 1'b0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            m_data_q       <= '0;
            layer_done_q   <= 1'b0;
`ifdef CONV_SEQ_WATCHDOG_EN
            wd_q           <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            w_we_q       <= 1'b0;
            b_we_q       <= 1'b0;
            i_we_q       <= 1'b0;
            start_q      <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            layer_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        count_err_q <= 1'b0;
`ifdef CONV_SEQ_WATCHDOG_EN
                        timeout_err_q <= 1'b0;
`endif
                        state_q <= go_w ? S_LOAD_W : S_LOAD_I;
                    end
                end
                S_LOAD_W: begin
                    if (s_valid_i) begin
                        w_we_q   <= 1'b1;
                        w_addr_q <= ld_cnt[AW_W-1:0];
                        w_data_q <= s_data_i[7:0];
                        if (ld_last) state_q <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (s_valid_i) begin
                        b_we_q   <= 1'b1;
                        b_addr_q <= ld_cnt[AW_B-1:0];
                        b_data_q <= s_data_i;
                        if (ld_last) begin
                            params_valid_q <= 1'b1;
                            state_q        <= S_LOAD_I;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (s_valid_i) begin
                        i_we_q   <= 1'b1;
                        i_addr_q <= ld_cnt[AW_I-1:0];
                        i_data_q <= s_data_i[7:0];
                        if (ld_last) state_q <= S_START;
                    end
                end
                S_START: begin
                    start_q   <= 1'b1;
                    out_cnt_q <= '0;
`ifdef CONV_SEQ_WATCHDOG_EN
                    wd_q      <= '0;
`endif
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    if (conv_valid_i) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= conv_result_i;
                        m_last_q  <= (out_cnt_q == OUT_LAST);
                        if (out_cnt_q == OUT_FULL) count_err_q <= 1'b1;
                    end
                    out_cnt_q <= out_cnt_d;
`ifdef CONV_SEQ_WATCHDOG_EN
                    wd_q <= conv_valid_i ? '0 : wd_q + 1'b1;
`endif
                    if (done_i) begin
                        if (out_cnt_d != OUT_FULL) count_err_q <= 1'b1;
                        state_q <= S_FINISH;
                    end
`ifdef CONV_SEQ_WATCHDOG_EN
                    else if (!conv_valid_i && wd_q == WD_LIMIT) begin
                        timeout_err_q <= 1'b1;
                        layer_done_q  <= 1'b1;
                        state_q       <= S_IDLE;
                    end
`endif
                end
                S_FINISH: begin
                    if (!done_i) begin
                        layer_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o      = (state_q == S_IDLE);
    assign s_ready_o        = (state_q == S_LOAD_W) || (state_q == S_LOAD_B) || (state_q == S_LOAD_I);
    assign busy_o           = (state_q != S_IDLE);
    assign weight_we_o      = w_we_q;
    assign weight_addr_o    = w_addr_q;
    assign weight_data_in_o = w_data_q;
    assign bias_we_o        = b_we_q;
    assign bias_addr_o      = b_addr_q;
    assign bias_data_in_o   = b_data_q;
    assign input_we_o       = i_we_q;
    assign input_addr_o     = i_addr_q;
    assign input_data_in_o  = i_data_q;
    assign start_o          = start_q;
    assign m_valid_o        = m_valid_q;
    assign m_data_o         = m_data_q;
    assign m_last_o         = m_last_q;
    assign layer_done_o     = layer_done_q;
    assign count_err_o      = count_err_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer with a write-plan / result-count scoreboard model.
module tb_conv_layer_sequencer;

    localparam int IC = 2, OC = 2, K = 3, H = 5, W = 5;
    localparam int N_W = OC * IC * K * K;
    localparam int N_B = OC;
    localparam int N_I = IC * H * W;
    localparam int N_O = OC * (H - K + 1) * (W - K + 1);

    logic        clk = 1'b0, rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_reload = 1'b0, cmd_ready;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0, s_ready;
    logic [7:0]  w_data, i_data;
    logic [31:0] b_data;
    logic        w_we, b_we, i_we;
    logic [5:0]  w_addr, i_addr;
    logic [0:0]  b_addr;
    logic        start, done = 1'b0, conv_valid = 1'b0;
    logic [7:0]  conv_result = '0, m_data;
    logic        m_valid, m_last, busy, layer_done, count_err, timeout_err;

    conv_layer_sequencer #(
        .INPUT_CHANNELS(IC), .OUTPUT_CHANNELS(OC), .KERNEL_SIZE(K),
        .INPUT_WIDTH(W), .INPUT_HEIGHT(H)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_reload_i(cmd_reload),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .weight_data_in_o(w_data), .weight_we_o(w_we), .weight_addr_o(w_addr),
        .bias_data_in_o(b_data), .bias_we_o(b_we), .bias_addr_o(b_addr),
        .input_data_in_o(i_data), .input_we_o(i_we), .input_addr_o(i_addr),
        .start_o(start), .done_i(done), .conv_result_i(conv_result), .conv_valid_i(conv_valid),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last),
        .busy_o(busy), .layer_done_o(layer_done), .count_err_o(count_err),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    int n_wwe = 0, n_bwe = 0, n_iwe = 0, n_start = 0, n_mv = 0, n_ml = 0, n_ld = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a plan of writes (port, address) built at command accept and consumed per beat,
    // plus layer phase flags and the result count k.
    int          plan_p[$], plan_a[$];
    bit          idle_m, run_m, fin_m, pv_m, err_m;
    int          start_at, k;
    bit          e_we0, e_we1, e_we2, e_mv, e_ml, e_ld;
    int          e_addr;
    logic [31:0] e_data;
    logic [7:0]  e_md;

    task automatic model_reset();
        plan_p.delete(); plan_a.delete();
        idle_m = 1; run_m = 0; fin_m = 0; pv_m = 0; err_m = 0;
        start_at = -1; k = 0;
        e_we0 = 0; e_we1 = 0; e_we2 = 0; e_mv = 0; e_ml = 0; e_ld = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!rstn) begin
            model_reset();
        end else begin
            n_wwe += int'(w_we); n_bwe += int'(b_we); n_iwe += int'(i_we);
            n_start += int'(start); n_mv += int'(m_valid); n_ml += int'(m_last); n_ld += int'(layer_done);

            chk("cmd_ready", cmd_ready, idle_m);
            chk("s_ready", s_ready, plan_p.size() != 0);
            chk("busy", busy, !idle_m);
            chk("start", start, cyc == start_at);
            chk("weight_we", w_we, e_we0);
            chk("bias_we", b_we, e_we1);
            chk("input_we", i_we, e_we2);
            if (e_we0) begin chk("weight_addr", w_addr, e_addr); chk("weight_data", w_data, e_data); end
            if (e_we1) begin chk("bias_addr", b_addr, e_addr); chk("bias_data", b_data, e_data); end
            if (e_we2) begin chk("input_addr", i_addr, e_addr); chk("input_data", i_data, e_data); end
            chk("m_valid", m_valid, e_mv);
            if (e_mv) chk("m_data", m_data, e_md);
            chk("m_last", m_last, e_ml);
            chk("layer_done", layer_done, e_ld);
            chk("count_err", count_err, err_m);
            chk("timeout_err", timeout_err, 0);

            e_we0 = 0; e_we1 = 0; e_we2 = 0; e_mv = 0; e_ml = 0; e_ld = 0;
            if (cyc == start_at) begin run_m = 1; k = 0; end
            if (idle_m) begin
                if (cmd_valid) begin
                    idle_m = 0; err_m = 0;
                    if (cmd_reload || !pv_m) begin
                        for (int i = 0; i < N_W; i++) begin plan_p.push_back(0); plan_a.push_back(i); end
                        for (int i = 0; i < N_B; i++) begin plan_p.push_back(1); plan_a.push_back(i); end
                    end
                    for (int i = 0; i < N_I; i++) begin plan_p.push_back(2); plan_a.push_back(i); end
                end
            end else if (plan_p.size() != 0) begin
                if (s_valid) begin
                    int p;
                    p = plan_p.pop_front();
                    e_addr = plan_a.pop_front();
                    e_data = (p == 1) ? s_data : {24'd0, s_data[7:0]};
                    e_we0 = (p == 0); e_we1 = (p == 1); e_we2 = (p == 2);
                    if (p == 1 && e_addr == N_B - 1) pv_m = 1;
                    if (plan_p.size() == 0) start_at = cyc + 2;
                end
            end else if (run_m) begin
                if (conv_valid) begin
                    k++;
                    e_mv = 1; e_md = conv_result; e_ml = (k == N_O);
                    if (k > N_O) err_m = 1;
                end
                if (done) begin
                    if (k != N_O) err_m = 1;
                    run_m = 0; fin_m = 1;
                end
            end else if (fin_m) begin
                if (!done) begin e_ld = 1; fin_m = 0; idle_m = 1; end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_we"}, {w_we, b_we, i_we}, 0);
        chk({tag, "_addr"}, {w_addr, b_addr, i_addr}, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_m"}, {m_valid, m_last, m_data}, 0);
        chk({tag, "_flags"}, {layer_done, count_err, timeout_err}, 0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'($urandom_range(1, 0)); s_data = $urandom;
            conv_valid = 1'($urandom_range(1, 0)); conv_result = 8'($urandom);
            tick();
        end
        s_valid = 0; conv_valid = 0;
    endtask

    task automatic run_layer(input bit reload, input int nres, input int vpct,
                             input int exp_w, input int exp_b, input int exp_err);
        int s_w, s_b, s_i, s_st, s_mv, s_ml, s_ld, guard;
        s_w = n_wwe; s_b = n_bwe; s_i = n_iwe; s_st = n_start; s_mv = n_mv; s_ml = n_ml; s_ld = n_ld;
        cmd_valid = 1; cmd_reload = reload; s_valid = 0;
        tick();
        cmd_valid = 0; cmd_reload = 0;
        chk("err_clear_on_cmd", count_err, 0);
        guard = 0;
        while (!start && guard < 3000) begin
            s_valid = ($urandom_range(99, 0) < vpct); s_data = $urandom;
            tick(); guard++;
        end
        s_valid = 0;
        chk("start_seen", start, 1);
        for (int i = 0; i < nres; i++) begin
            repeat ($urandom_range(2, 0)) tick();
            conv_valid = 1; conv_result = 8'($urandom);
            tick();
            conv_valid = 0;
        end
        repeat ($urandom_range(3, 1)) tick();
        done = 1;
        repeat ($urandom_range(3, 1)) tick();
        done = 0;
        guard = 0;
        while (!layer_done && guard < 20) begin tick(); guard++; end
        chk("layer_done_seen", layer_done, 1);
        tick();
        chk("L_weight_writes", n_wwe - s_w, exp_w);
        chk("L_bias_writes", n_bwe - s_b, exp_b);
        chk("L_input_writes", n_iwe - s_i, N_I);
        chk("L_start_pulses", n_start - s_st, 1);
        chk("L_results", n_mv - s_mv, nres);
        chk("L_last_flags", n_ml - s_ml, (nres >= N_O) ? 1 : 0);
        chk("L_layer_done", n_ld - s_ld, 1);
        chk("L_count_err", count_err, exp_err);
    endtask

    initial begin
        int s_i, guard;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rstn = 1;
        idle_gap(4);

        run_layer(1, N_O, 100, N_W, N_B, 0);
        idle_gap(3);
        run_layer(0, N_O, 50, 0, 0, 0);
        idle_gap(3);
        run_layer(0, N_O - 1, 60, 0, 0, 1);
        idle_gap(2);
        run_layer(0, N_O + 2, 80, 0, 0, 1);
        idle_gap(3);

        cmd_valid = 1; cmd_reload = 1;
        tick();
        cmd_valid = 0; cmd_reload = 0;
        s_i = n_iwe; guard = 0;
        while (n_iwe - s_i < 10 && guard < 500) begin
            s_valid = 1; s_data = $urandom;
            tick(); guard++;
        end
        chk("reached_load_i", n_iwe - s_i >= 10, 1);
        rstn = 0;
        #1;
        check_reset_vals("midreset");
        tick();
        rstn = 1; s_valid = 0;
        idle_gap(2);
        run_layer(0, N_O, 70, N_W, N_B, 0);
        idle_gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
